// File: rtl/pb_gpio_regs.sv
// Picoblaze GPIO register bank: port decode, pin control registers, edge-detect status and IRQ FSM.
// Optional input debounce filter is enabled with the PB_GPIO_REGS_DEBOUNCE_EN macro.
module pb_gpio_regs #(
  parameter logic [7:0]  BASE_ADDR    = 8'h10,
  parameter logic [15:0] DEBOUNCE_DIV = 16'd1000
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [7:0] port_id_i,
  input  logic       write_strobe_i,
  input  logic       read_strobe_i,
  input  logic [7:0] out_port_i,
  output logic [7:0] in_port_o,
  output logic       interrupt_o,
  input  logic       interrupt_ack_i,
  output logic [7:0] gpio_oe_o,
  output logic [7:0] gpio_enable_o,
  output logic [7:0] gpio_data_o,
  input  logic [7:0] gpio_data_i
);

  localparam logic [2:0] OFF_DOUT    = 3'd0;
  localparam logic [2:0] OFF_OE      = 3'd1;
  localparam logic [2:0] OFF_EN      = 3'd2;
  localparam logic [2:0] OFF_DIN     = 3'd3;
  localparam logic [2:0] OFF_RISE_EN = 3'd4;
  localparam logic [2:0] OFF_FALL_EN = 3'd5;
  localparam logic [2:0] OFF_STATUS  = 3'd6;
  localparam logic [2:0] OFF_CTRL    = 3'd7;

  typedef enum logic [1:0] {
    IRQ_IDLE   = 2'd0,
    IRQ_ASSERT = 2'd1,
    IRQ_WAIT   = 2'd2
  } irq_state_t;

  logic [7:0] dout_q;
  logic [7:0] oe_q;
  logic [7:0] en_q;
  logic [7:0] rise_en_q;
  logic [7:0] fall_en_q;
  logic [7:0] status_q;
  logic       gie_q;
  logic [7:0] prev_q;
  logic [7:0] in_port_q;
  logic       irq_q;
  irq_state_t irq_state_q;

  logic       win_hit;
  logic [2:0] offset;
  logic       wr_en;
  logic [7:0] din;
  logic [7:0] rise_evt;
  logic [7:0] fall_evt;
  logic [7:0] new_evt;
  logic [7:0] clr;
  logic [7:0] status_next;
  logic       pending;
  logic [7:0] rd_data;

  assign win_hit = (port_id_i[7:3] == BASE_ADDR[7:3]);
  assign offset  = port_id_i[2:0];
  assign wr_en   = write_strobe_i & win_hit;

`ifdef PB_GPIO_REGS_DEBOUNCE_EN
  logic [15:0] presc_q;
  logic        tick;
  logic [7:0]  samp0_q;
  logic [7:0]  samp1_q;
  logic [7:0]  filt_q;
  logic        unused_ok;

  assign tick = (presc_q == DEBOUNCE_DIV - 16'd1);

  // A filtered bit only moves when the last two tick samples agree.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      presc_q <= 16'd0;
      samp0_q <= 8'd0;
      samp1_q <= 8'd0;
      filt_q  <= 8'd0;
    end else begin
      if (tick) begin
        presc_q <= 16'd0;
        samp1_q <= samp0_q;
        samp0_q <= gpio_data_i;
      end else begin
        presc_q <= presc_q + 16'd1;
      end
      filt_q <= (samp0_q & samp1_q) | (filt_q & (samp0_q ^ samp1_q));
    end
  end

  assign din       = filt_q;
  assign unused_ok = ^{read_strobe_i, BASE_ADDR[2:0]};
`else
  logic unused_ok;

  assign din       = gpio_data_i;
  assign unused_ok = ^{read_strobe_i, BASE_ADDR[2:0], DEBOUNCE_DIV};
`endif

  assign rise_evt    = din & ~prev_q & rise_en_q;
  assign fall_evt    = ~din & prev_q & fall_en_q;
  assign new_evt     = rise_evt | fall_evt;
  assign clr         = (wr_en && offset == OFF_STATUS) ? out_port_i : 8'd0;
  // New events are OR-ed in after the clear so a coincident set survives.
  assign status_next = (status_q & ~clr) | new_evt;
  assign pending     = gie_q & (status_q != 8'd0);

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      dout_q    <= 8'd0;
      oe_q      <= 8'd0;
      en_q      <= 8'd0;
      rise_en_q <= 8'd0;
      fall_en_q <= 8'd0;
      gie_q     <= 1'b0;
      status_q  <= 8'd0;
      prev_q    <= 8'd0;
    end else begin
      if (wr_en) begin
        case (offset)
          OFF_DOUT:    dout_q    <= out_port_i;
          OFF_OE:      oe_q      <= out_port_i;
          OFF_EN:      en_q      <= out_port_i;
          OFF_RISE_EN: rise_en_q <= out_port_i;
          OFF_FALL_EN: fall_en_q <= out_port_i;
          OFF_CTRL:    gie_q     <= out_port_i[0];
          default:     ;
        endcase
      end
      status_q <= status_next;
      prev_q   <= din;
    end
  end

  always_comb begin
    rd_data = 8'd0;
    if (win_hit) begin
      case (offset)
        OFF_DOUT:    rd_data = dout_q;
        OFF_OE:      rd_data = oe_q;
        OFF_EN:      rd_data = en_q;
        OFF_DIN:     rd_data = din;
        OFF_RISE_EN: rd_data = rise_en_q;
        OFF_FALL_EN: rd_data = fall_en_q;
        OFF_STATUS:  rd_data = status_q;
        OFF_CTRL:    rd_data = {7'd0, gie_q};
        default:     rd_data = 8'd0;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      in_port_q <= 8'd0;
    end else begin
      in_port_q <= rd_data;
    end
  end

  // WAIT holds off re-raising until firmware clears STATUS, unless a fresh event arrives.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      irq_state_q <= IRQ_IDLE;
      irq_q       <= 1'b0;
    end else begin
      case (irq_state_q)
        IRQ_IDLE: begin
          if (pending) begin
            irq_state_q <= IRQ_ASSERT;
            irq_q       <= 1'b1;
          end
        end
        IRQ_ASSERT: begin
          if (interrupt_ack_i) begin
            irq_state_q <= IRQ_WAIT;
            irq_q       <= 1'b0;
          end else if (!pending) begin
            irq_state_q <= IRQ_IDLE;
            irq_q       <= 1'b0;
          end
        end
        IRQ_WAIT: begin
          if ((new_evt != 8'd0) && gie_q) begin
            irq_state_q <= IRQ_ASSERT;
            irq_q       <= 1'b1;
          end else if (!pending) begin
            irq_state_q <= IRQ_IDLE;
          end
        end
        default: begin
          irq_state_q <= IRQ_IDLE;
          irq_q       <= 1'b0;
        end
      endcase
    end
  end

  assign in_port_o     = in_port_q;
  assign interrupt_o   = irq_q;
  assign gpio_data_o   = dout_q;
  assign gpio_oe_o     = oe_q;
  assign gpio_enable_o = en_q;

endmodule

// File: tb/tb_pb_gpio_regs.sv
// Directed bench for pb_gpio_regs: register access, edge/status/IRQ sequencing, reset, optional debounce.
module tb_pb_gpio_regs;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic [7:0] port_id_i;
  logic       write_strobe_i;
  logic       read_strobe_i;
  logic [7:0] out_port_i;
  logic [7:0] in_port_o;
  logic       interrupt_o;
  logic       interrupt_ack_i;
  logic [7:0] gpio_oe_o;
  logic [7:0] gpio_enable_o;
  logic [7:0] gpio_data_o;
  logic [7:0] gpio_data_i;

  logic [7:0] exp_q[$];
  int checks = 0;
  int errors = 0;

  pb_gpio_regs #(
    .BASE_ADDR   (8'h10),
    .DEBOUNCE_DIV(16'd4)
  ) dut (
    .clk_i          (clk_i),
    .rst_i          (rst_i),
    .port_id_i      (port_id_i),
    .write_strobe_i (write_strobe_i),
    .read_strobe_i  (read_strobe_i),
    .out_port_i     (out_port_i),
    .in_port_o      (in_port_o),
    .interrupt_o    (interrupt_o),
    .interrupt_ack_i(interrupt_ack_i),
    .gpio_oe_o      (gpio_oe_o),
    .gpio_enable_o  (gpio_enable_o),
    .gpio_data_o    (gpio_data_o),
    .gpio_data_i    (gpio_data_i)
  );

  always #5 clk_i = ~clk_i;

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic push_exp(input logic [7:0] e);
    exp_q.push_back(e);
  endtask

  task automatic check(input string tag, input logic [7:0] obs);
    logic [7:0] e;
    e = exp_q.pop_front();
    checks++;
    assert (obs === e) else begin
      errors++;
      $error("FAIL %s observed=%02h expected=%02h", tag, obs, e);
    end
  endtask

  task automatic check_irq(input string tag, input logic e);
    push_exp({7'd0, e});
    check(tag, {7'd0, interrupt_o});
  endtask

  task automatic wr(input logic [7:0] addr, input logic [7:0] data);
    port_id_i      = addr;
    out_port_i     = data;
    write_strobe_i = 1'b1;
    read_strobe_i  = 1'b0;
    tick();
    write_strobe_i = 1'b0;
  endtask

  task automatic rd(input string tag, input logic [7:0] addr, input logic [7:0] e);
    port_id_i     = addr;
    read_strobe_i = 1'b1;
    push_exp(e);
    tick();
    read_strobe_i = 1'b0;
    check(tag, in_port_o);
  endtask

  initial begin
    rst_i           = 1'b1;
    port_id_i       = 8'h00;
    write_strobe_i  = 1'b0;
    read_strobe_i   = 1'b0;
    out_port_i      = 8'h00;
    interrupt_ack_i = 1'b0;
    gpio_data_i     = 8'h00;
    repeat (3) tick();
    rst_i = 1'b0;

    push_exp(8'h00); check("rst_dout", gpio_data_o);
    push_exp(8'h00); check("rst_oe", gpio_oe_o);
    push_exp(8'h00); check("rst_en", gpio_enable_o);
    push_exp(8'h00); check("rst_inport", in_port_o);
    check_irq("rst_irq", 1'b0);

    // Register writes and readback
    wr(8'h10, 8'hA5);
    wr(8'h11, 8'h0F);
    wr(8'h12, 8'hFF);
    push_exp(8'hA5); check("dout_out", gpio_data_o);
    push_exp(8'h0F); check("oe_out", gpio_oe_o);
    push_exp(8'hFF); check("en_out", gpio_enable_o);
    rd("rd_dout", 8'h10, 8'hA5);
    rd("rd_oe", 8'h11, 8'h0F);
    rd("rd_en", 8'h12, 8'hFF);
    rd("rd_miss", 8'h20, 8'h00);
    wr(8'h13, 8'hFF);
    rd("rd_din_ro", 8'h13, 8'h00);
    rd("rd_ctrl0", 8'h17, 8'h00);

`ifndef PB_GPIO_REGS_DEBOUNCE_EN
    // Rising edge on bit0 -> STATUS then interrupt two edges later
    wr(8'h14, 8'h01);
    wr(8'h17, 8'h01);
    gpio_data_i = 8'h01;
    tick();
    check_irq("irq_k1", 1'b0);
    tick();
    check_irq("irq_k2", 1'b1);
    rd("rd_status1", 8'h16, 8'h01);
    rd("rd_din1", 8'h13, 8'h01);
    rd("rd_ctrl1", 8'h17, 8'h01);
    interrupt_ack_i = 1'b1;
    tick();
    interrupt_ack_i = 1'b0;
    check_irq("irq_ack", 1'b0);
    tick();
    check_irq("irq_wait_hold", 1'b0);
    wr(8'h16, 8'h01);
    tick();
    check_irq("irq_idle", 1'b0);
    rd("rd_status_clr", 8'h16, 8'h00);

    // Fresh event while in WAIT re-raises the interrupt
    gpio_data_i = 8'h00;
    tick();
    gpio_data_i = 8'h01;
    tick();
    tick();
    check_irq("irq_second", 1'b1);
    interrupt_ack_i = 1'b1;
    tick();
    interrupt_ack_i = 1'b0;
    check_irq("irq_ack2", 1'b0);
    wr(8'h14, 8'h03);
    gpio_data_i = 8'h03;
    tick();
    check_irq("irq_reassert", 1'b1);
    rd("rd_status3", 8'h16, 8'h03);
    interrupt_ack_i = 1'b1;
    tick();
    interrupt_ack_i = 1'b0;
    check_irq("irq_ack3", 1'b0);
    wr(8'h16, 8'h03);
    tick();
    check_irq("irq_idle2", 1'b0);

    // Falling edge coincident with W1C of the same bit: set wins
    wr(8'h15, 8'h80);
    gpio_data_i = 8'h83;
    tick();
    port_id_i      = 8'h16;
    out_port_i     = 8'h80;
    write_strobe_i = 1'b1;
    gpio_data_i    = 8'h03;
    tick();
    write_strobe_i = 1'b0;
    rd("rd_set_wins", 8'h16, 8'h80);
    check_irq("irq_set_wins", 1'b1);
    wr(8'h17, 8'h00);
    check_irq("irq_gie_drop0", 1'b1);
    tick();
    check_irq("irq_gie_drop1", 1'b0);

    // GIE=0: event logged but no interrupt until GIE is set
    wr(8'h16, 8'hFF);
    gpio_data_i = 8'h82;
    tick();
    gpio_data_i = 8'h02;
    tick();
    tick();
    tick();
    check_irq("irq_gie_off", 1'b0);
    rd("rd_status_gie_off", 8'h16, 8'h80);
    wr(8'h17, 8'h01);
    tick();
    check_irq("irq_gie_on", 1'b1);

    // Reset while the interrupt is asserted
    rst_i       = 1'b1;
    gpio_data_i = 8'h00;
    tick();
    check_irq("irq_rst", 1'b0);
    rst_i = 1'b0;
    push_exp(8'h00); check("rst2_dout", gpio_data_o);
    push_exp(8'h00); check("rst2_oe", gpio_oe_o);
    push_exp(8'h00); check("rst2_en", gpio_enable_o);
    for (int i = 0; i < 8; i++) begin
      rd("rd_after_rst", 8'h10 + 8'(i), 8'h00);
    end
    tick();
    check_irq("irq_after_rst", 1'b0);
`else
    // Debounce: short glitch filtered, held level logged
    wr(8'h14, 8'h04);
    gpio_data_i = 8'h04;
    repeat (3) tick();
    gpio_data_i = 8'h00;
    repeat (10) tick();
    rd("db_glitch_status", 8'h16, 8'h00);
    rd("db_glitch_din", 8'h13, 8'h00);
    gpio_data_i = 8'h04;
    repeat (12) tick();
    rd("db_level_din", 8'h13, 8'h04);
    rd("db_level_status", 8'h16, 8'h04);
    check_irq("db_irq_gie_off", 1'b0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/pb_gpio_regs.md
# pb_gpio_regs

Firmware-side register bank for the Picoblaze GPIO pin block. It decodes Picoblaze INPUT/OUTPUT port cycles and holds the output-enable, pin-enable and output-data registers that drive the pin block. It samples the pin block's captured input byte and detects per-bit rising and falling edges into a sticky write-1-to-clear status register. It raises the Picoblaze interrupt through an assert/acknowledge state machine.

## Interface
- BASE_ADDR, 8'h10, port window base; bits [2:0] ignored, window is 8 ports
- DEBOUNCE_DIV, 16'd1000, debounce sample period in clk_i cycles (used only with PB_GPIO_REGS_DEBOUNCE_EN)

- clk_i  in  1  system clock
- rst_i  in  1  reset, synchronous, active-high
- port_id_i  in  8  Picoblaze port address
- write_strobe_i  in  1  Picoblaze OUTPUT strobe
- read_strobe_i  in  1  Picoblaze INPUT strobe (no read side effects; unused internally)
- out_port_i  in  8  write data from Picoblaze
- in_port_o  out  8  read data to Picoblaze; 0 when port_id_i is outside the window (OR-able bus)
- interrupt_o  out  1  Picoblaze interrupt request
- interrupt_ack_i  in  1  Picoblaze interrupt acknowledge
- gpio_oe_o  out  8  per-bit output enable to pin block
- gpio_enable_o  out  8  per-bit pin enable to pin block
- gpio_data_o  out  8  output data to pin block
- gpio_data_i  in  8  captured input byte from pin block (already registered, masked by !oe & enable)

## Operation
- Window hit: port_id_i[7:3] == BASE_ADDR[7:3]. Offset: port_id_i[2:0].
- Registers, by offset:
  - 0 DOUT, RW, drives gpio_data_o
  - 1 OE, RW, drives gpio_oe_o
  - 2 EN, RW, drives gpio_enable_o
  - 3 DIN, RO, filtered input; writes ignored
  - 4 RISE_EN, RW
  - 5 FALL_EN, RW
  - 6 STATUS, W1C
  - 7 CTRL, RW; bit0 = GIE, bits[7:1] read 0
- Write: on any clk_i edge with write_strobe_i=1 and window hit, the addressed register takes out_port_i.
- Read: in_port_o is registered. Each cycle it takes the register selected by the current port_id_i, or 0 on a miss.
- Edge detect: prev register tracks the filtered input every cycle.
  - rise = in & ~prev & RISE_EN
  - fall = ~in & prev & FALL_EN
  - new = rise | fall
- STATUS update: STATUS <= (STATUS & ~clr) | new. clr is out_port_i on a STATUS write, else 0. A set wins over a simultaneous clear of the same bit.
- pending = GIE & (STATUS != 0).
- IRQ FSM (interrupt_o = 1 only in ASSERT):
  - IDLE → ASSERT when pending.
  - ASSERT → WAIT on interrupt_ack_i. ASSERT → IDLE if pending drops (GIE cleared, or STATUS cleared) before ack.
  - WAIT → IDLE when pending == 0. WAIT → ASSERT when new != 0 and GIE=1, so a fresh event during service re-interrupts.
  - interrupt_ack_i outside ASSERT is ignored.
- Reset values:
  - all registers, prev, and in_port_o: 0
  - interrupt_o: 0
  - FSM: IDLE
  - debounce state: 0

## Timing
- Register write visible on the output ports in the cycle after the strobe edge.
- in_port_o valid 1 cycle after port_id_i is stable. This meets the Picoblaze 2-cycle INPUT window.
- Latencies without debounce:
  - gpio_data_i changes after edge k → STATUS bit set at edge k+1.
  - interrupt_o high after edge k+2.
- Ack sampled at edge a → interrupt_o low after edge a.
- Reset mid-service: the FSM returns to IDLE and interrupt_o drops on the reset edge. A pending STATUS is lost.

## Configuration
- PB_GPIO_REGS_DEBOUNCE_EN defined:
  - A 16-bit prescaler counts 0..DEBOUNCE_DIV-1 and pulses tick on wrap.
  - On each tick, each bit shifts gpio_data_i into a 2-deep sample history.
  - The filtered bit updates only when both samples agree.
  - DIN and edge detect use the filtered value. Edge latency grows to at most 2·DEBOUNCE_DIV+2 cycles.
  - A glitch shorter than one tick period causes no event.
- Not defined: the filtered value is gpio_data_i directly, there is no prescaler logic, and DEBOUNCE_DIV is ignored.

## Test plan
- Write 8'hA5 to BASE+0, 8'h0F to BASE+1, 8'hFF to BASE+2 → next cycle gpio_data_o=A5, gpio_oe_o=0F, gpio_enable_o=FF. Reads of offsets 0/1/2 return the same values. A read at port_id 8'h20 returns 0.
- RISE_EN=01, GIE=1, gpio_data_i 00→01 → STATUS=01 and interrupt_o=1 two cycles later. Pulse interrupt_ack_i → interrupt_o=0. Write 01 to BASE+6 → STATUS=00, FSM returns to IDLE.
- FALL_EN=80, bit7 1→0 in the same cycle as a W1C write of 80 → STATUS bit7 stays 1 (set wins).
- In WAIT, raise bit1 with RISE_EN=02 → interrupt_o re-asserts. With GIE=0, an edge sets STATUS but interrupt_o stays 0 until GIE=1 is written.
- Assert rst_i while interrupt_o=1 → next cycle interrupt_o=0 and all registers read 0.
- With the macro and DEBOUNCE_DIV=4: a 3-cycle pulse on bit2 → no STATUS change. A level held for 12 cycles → DIN bit2=1 and a rising event is logged.
